// File: rtl/inst_fetch_mem.sv
// Byte-addressed big-endian instruction memory with a fetch request/response
// handshake, programmable wait states and a word-load port.
module inst_fetch_mem #(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] NOP_INST    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] pc,
    output logic        ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic        fault,
    input  logic        rsp_ready,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic        ld_err,
    output logic [31:0] fetch_cnt
);

    localparam int unsigned AW        = $clog2(DEPTH_BYTES);
    localparam logic [31:0] LAST_WORD = 32'(DEPTH_BYTES - 4);
    // Counter is preloaded one below WAIT_STATES so WAIT lasts exactly WAIT_STATES cycles.
    localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_t;

    logic [7:0]  mem [DEPTH_BYTES];

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic        rdy_en_q;
    logic [31:0] inst_q;
    logic        fault_q;
    logic        ld_err_q;
    logic [31:0] cnt_q;

    logic          accept;
    logic          pc_bad;
    logic          ld_bad;
    logic [AW-3:0] pc_w;
    logic [AW-3:0] ld_w;
    logic [31:0]   rd_word;

    assign pc_bad = (pc[1:0] != 2'b00) || (pc > LAST_WORD);
    assign ld_bad = (ld_addr[1:0] != 2'b00) || (ld_addr > LAST_WORD);
    assign pc_w   = pc[AW-1:2];
    assign ld_w   = ld_addr[AW-1:2];

    assign rd_word = {mem[{pc_w, 2'd0}], mem[{pc_w, 2'd1}],
                      mem[{pc_w, 2'd2}], mem[{pc_w, 2'd3}]};

    // rdy_en_q keeps ready low while reset is held and until the first edge after release.
    assign ready  = rdy_en_q && ((state_q == StIdle) || ((state_q == StResp) && rsp_ready));
    assign accept = req && ready;

    assign inst_valid = (state_q == StResp);
    assign inst       = inst_q;
    assign fault      = fault_q;
    assign ld_err     = ld_err_q;
    assign fetch_cnt  = cnt_q;

    // Next-state logic: count down wait states, release on response handshake.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            StIdle: state_d = StIdle;
            StWait: begin
                if (wait_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // A new acceptance overrides the IDLE/RESP outcome above.
        if (accept) begin
            state_d = (WAIT_STATES > 0) ? StWait : StResp;
            wait_d  = WAIT_INIT;
        end
    end

    // Control state, holding register and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            wait_q   <= 4'd0;
            rdy_en_q <= 1'b0;
            inst_q   <= NOP_INST;
            fault_q  <= 1'b0;
            ld_err_q <= 1'b0;
            cnt_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            rdy_en_q <= 1'b1;
            ld_err_q <= ld_en && ld_bad;
            if (accept) begin
                // Captured at the accepting edge, so a same-edge load is not seen.
                inst_q  <= pc_bad ? NOP_INST : rd_word;
                fault_q <= pc_bad;
            end
            if ((state_q == StResp) && rsp_ready) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    // Array write port; deliberately unreset so contents survive reset.
    always_ff @(posedge clk) begin
        if (ld_en && !ld_bad) begin
            mem[{ld_w, 2'd0}] <= ld_data[31:24];
            mem[{ld_w, 2'd1}] <= ld_data[23:16];
            mem[{ld_w, 2'd2}] <= ld_data[15:8];
            mem[{ld_w, 2'd3}] <= ld_data[7:0];
        end
    end

endmodule
